// File: rtl/or1200_trace_pkg.sv
// Shared constants and FSM encoding for the OR1200 retired-instruction trace buffer.
package or1200_trace_pkg;

   localparam logic [31:0] NOP_EXIT   = 32'h1500_0001;
   localparam logic [31:0] NOP_REPORT = 32'h1500_0002;
   localparam logic [31:0] NOP_PUTC   = 32'h1500_0004;

   localparam int TRACE_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } trace_state_e;

endpackage

// File: rtl/or1200_insn_trace_if.sv
// Writeback sample inputs and the trace record stream, bundled for the trace buffer.
interface or1200_insn_trace_if;
   import or1200_trace_pkg::*;

   logic               wb_valid_i;
   logic [31:0]        wb_insn_i;
   logic [31:0]        wb_pc_i;
   logic               m_valid_o;
   logic [TRACE_W-1:0] m_data_o;
   logic               m_ready_i;

   modport slave (
      input  wb_valid_i,
      input  wb_insn_i,
      input  wb_pc_i,
      output m_valid_o,
      output m_data_o,
      input  m_ready_i
   );

   modport master (
      output wb_valid_i,
      output wb_insn_i,
      output wb_pc_i,
      input  m_valid_o,
      input  m_data_o,
      output m_ready_i
   );

endinterface

// File: rtl/or1200_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and occupancy output.
module or1200_trace_fifo #(
   parameter int W  = 64,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic         full_o,
   output logic [AW:0]  level_o
);

   logic [W-1:0] mem [2**AW];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         empty;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign valid_o = !empty;
   assign level_o = wr_ptr_q - rd_ptr_q;

   // A push into a full FIFO is legal only when the head leaves on the same edge.
   assign do_pop  = pop_i && !empty;
   assign do_push = push_i && (!full_o || do_pop);

   // Stale storage is masked so the head reads zero whenever nothing is queued.
   assign data_o  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/or1200_insn_trace.sv
// Retired-instruction trace buffer: capture FSM, l.nop simulation-control decode,
// overflow accounting and a FIFO draining through a valid/ready stream.
module or1200_insn_trace
   import or1200_trace_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int OVF_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable_i,
   or1200_insn_trace_if.slave    trc,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic [OVF_W-1:0]      ovf_cnt_o,
   output logic                  nop_exit_o,
   output logic                  nop_report_o,
   output logic                  halted_o
);

   trace_state_e     state_q, state_d;
   logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
   logic             nop_exit_q, nop_exit_d;
   logic             nop_report_q, nop_report_d;

   logic accept;
   logic pop;
   logic fifo_full;
   logic drop;
   logic is_exit;
   logic is_report;

   assign accept    = (state_q == ST_RUN) && trc.wb_valid_i;
   assign pop       = trc.m_valid_o && trc.m_ready_i;
   assign drop      = accept && fifo_full && !pop;
   assign is_exit   = accept && (trc.wb_insn_i == NOP_EXIT);
   assign is_report = accept && (trc.wb_insn_i == NOP_REPORT);

   or1200_trace_fifo #(
      .W  (TRACE_W),
      .AW (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .data_i  ({trc.wb_pc_i, trc.wb_insn_i}),
      .pop_i   (pop),
      .data_o  (trc.m_data_o),
      .valid_o (trc.m_valid_o),
      .full_o  (fifo_full),
      .level_o (level_o)
   );

   // An exit retire wins over a simultaneous disable: once seen, capture stops for good.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (enable_i) state_d = ST_RUN;
         ST_RUN: begin
            if (is_exit)        state_d = ST_HALT;
            else if (!enable_i) state_d = ST_IDLE;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ovf_cnt_d    = ovf_cnt_q;
      nop_exit_d   = nop_exit_q || is_exit;
      nop_report_d = is_report;
      if (drop && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ovf_cnt_q    <= '0;
         nop_exit_q   <= 1'b0;
         nop_report_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ovf_cnt_q    <= ovf_cnt_d;
         nop_exit_q   <= nop_exit_d;
         nop_report_q <= nop_report_d;
      end
   end

   assign ovf_cnt_o    = ovf_cnt_q;
   assign nop_exit_o   = nop_exit_q;
   assign nop_report_o = nop_report_q;
   assign halted_o     = (state_q == ST_HALT);

endmodule

// File: tb/tb_or1200_insn_trace.sv
// Scoreboard bench for or1200_insn_trace: directed retires push expected records,
// a negedge monitor pops and compares every accepted trace record.
module tb_or1200_insn_trace;
   import or1200_trace_pkg::*;

   logic        clk;
   logic        rst;
   logic        enable_i;
   logic [4:0]  level_o;
   logic [15:0] ovf_cnt_o;
   logic        nop_exit_o;
   logic        nop_report_o;
   logic        halted_o;

   int total;
   int bad;

   logic [63:0] exp_q [$];

   or1200_insn_trace_if trc_if ();

   or1200_insn_trace #(
      .DEPTH_LOG2 (4),
      .OVF_W      (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .trc          (trc_if),
      .level_o      (level_o),
      .ovf_cnt_o    (ovf_cnt_o),
      .nop_exit_o   (nop_exit_o),
      .nop_report_o (nop_report_o),
      .halted_o     (halted_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one retire for a single clock; expected records enter the scoreboard here.
   task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] insn, input bit expect_push);
      trc_if.wb_valid_i = 1'b1;
      trc_if.wb_pc_i    = pc;
      trc_if.wb_insn_i  = insn;
      if (expect_push) exp_q.push_back({pc, insn});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      trc_if.wb_valid_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string name);
      int cycles;
      trc_if.wb_valid_i = 1'b0;
      cycles = 0;
      while ((level_o != 5'd0 || exp_q.size() != 0) && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check_output({name, "_level_zero"}, 64'(level_o), 64'd0);
      check_output({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && trc_if.m_valid_o && trc_if.m_ready_i) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_record: got %h expected none", trc_if.m_data_o);
         end else begin
            check_output("record", trc_if.m_data_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      enable_i          = 1'b0;
      trc_if.wb_valid_i = 1'b0;
      trc_if.wb_pc_i    = '0;
      trc_if.wb_insn_i  = '0;
      trc_if.m_ready_i  = 1'b0;

      @(negedge clk);
      check_output("rst_m_valid", 64'(trc_if.m_valid_o), 64'd0);
      check_output("rst_m_data", trc_if.m_data_o, 64'd0);
      check_output("rst_level", 64'(level_o), 64'd0);
      check_output("rst_ovf", 64'(ovf_cnt_o), 64'd0);
      check_output("rst_exit", 64'(nop_exit_o), 64'd0);
      check_output("rst_report", 64'(nop_report_o), 64'd0);
      check_output("rst_halted", 64'(halted_o), 64'd0);

      @(posedge clk);
      #1;
      rst = 1'b0;
      enable_i = 1'b1;
      trc_if.m_ready_i = 1'b1;
      idle_cycles(1);

      $display("[TB] basic trace");
      apply_stimulus(32'h0000_0100, 32'hE000_1000, 1'b1);
      check_output("basic_valid", 64'(trc_if.m_valid_o), 64'd1);
      check_output("basic_head", trc_if.m_data_o, 64'h0000_0100_E000_1000);
      apply_stimulus(32'h0000_0104, 32'h1500_0000, 1'b1);
      wait_drain("basic");

      $display("[TB] overflow");
      trc_if.m_ready_i = 1'b0;
      for (int i = 0; i < 20; i++)
         apply_stimulus(32'h0000_0200 + 32'(4 * i), 32'h1100_0000 + 32'(i), i < 16);
      idle_cycles(1);
      check_output("ovf_level", 64'(level_o), 64'd16);
      check_output("ovf_count", 64'(ovf_cnt_o), 64'd4);

      $display("[TB] full with push and pop");
      trc_if.m_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(32'h0000_0300 + 32'(4 * i), 32'h1200_0000 + 32'(i), 1'b1);
         check_output("fullpp_level", 64'(level_o), 64'd16);
      end
      check_output("fullpp_ovf", 64'(ovf_cnt_o), 64'd4);
      wait_drain("fullpp");

      $display("[TB] report and disable");
      apply_stimulus(32'h0000_0400, NOP_REPORT, 1'b1);
      check_output("report_pulse", 64'(nop_report_o), 64'd1);
      apply_stimulus(32'h0000_0404, NOP_PUTC, 1'b1);
      check_output("report_clear", 64'(nop_report_o), 64'd0);
      check_output("putc_no_exit", 64'(nop_exit_o), 64'd0);
      idle_cycles(1);
      enable_i = 1'b0;
      idle_cycles(1);
      apply_stimulus(32'h0000_0408, 32'hE000_2000, 1'b0);
      idle_cycles(1);
      check_output("disable_ovf", 64'(ovf_cnt_o), 64'd4);
      wait_drain("disable");
      enable_i = 1'b1;
      idle_cycles(1);

      $display("[TB] exit");
      trc_if.m_ready_i = 1'b0;
      apply_stimulus(32'h0000_0500, NOP_EXIT, 1'b1);
      check_output("exit_flag", 64'(nop_exit_o), 64'd1);
      check_output("exit_halted", 64'(halted_o), 64'd1);
      for (int i = 0; i < 3; i++)
         apply_stimulus(32'h0000_0504 + 32'(4 * i), 32'hE000_3000, 1'b0);
      check_output("exit_level", 64'(level_o), 64'd1);
      check_output("exit_ovf", 64'(ovf_cnt_o), 64'd4);
      trc_if.m_ready_i = 1'b1;
      wait_drain("exit");
      check_output("exit_sticky", 64'(nop_exit_o), 64'd1);

      $display("[TB] reset returns to idle");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_output("rerst_halted", 64'(halted_o), 64'd0);
      check_output("rerst_exit", 64'(nop_exit_o), 64'd0);
      apply_stimulus(32'h0000_0600, 32'hE000_4000, 1'b0);
      check_output("idle_no_push", 64'(level_o), 64'd0);

      $display("[TB] async reset mid-drain");
      trc_if.m_ready_i = 1'b0;
      for (int i = 0; i < 5; i++)
         apply_stimulus(32'h0000_0700 + 32'(4 * i), 32'hE000_5000 + 32'(i), 1'b0);
      trc_if.wb_valid_i = 1'b0;
      check_output("mid_level", 64'(level_o), 64'd5);
      trc_if.m_ready_i = 1'b1;
      rst = 1'b1;
      #1;
      check_output("arst_m_valid", 64'(trc_if.m_valid_o), 64'd0);
      check_output("arst_m_data", trc_if.m_data_o, 64'd0);
      check_output("arst_level", 64'(level_o), 64'd0);
      check_output("arst_halted", 64'(halted_o), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycles(2);
      check_output("final_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/or1200_insn_trace.md
# or1200_insn_trace

Retired-instruction trace buffer for the OR1200 generic system. It samples the CPU writeback stage (`or1200_ctrl` writeback instruction word plus PC) and queues {PC, instruction} records in a small FIFO. The FIFO drains through a valid/ready stream to a downstream sink such as a UART or JTAG trace drain, or a bench monitor. It also decodes simulation-control `l.nop` codes: it flags exit, it pulses report, and after exit it stops capturing.

## Interface
- `DEPTH_LOG2`, 4: log2 of FIFO depth (16 entries).
- `OVF_W`, 16: overflow counter width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  capture enable.
- `wb_valid_i`  in  1  one-cycle strobe: an instruction retired this cycle.
- `wb_insn_i`  in  32  retired instruction word.
- `wb_pc_i`  in  32  retired instruction address.
- `m_valid_o`  out  1  trace record available.
- `m_data_o`  out  64  record {`wb_pc_i`, `wb_insn_i`}, PC in [63:32].
- `m_ready_i`  in  1  sink accepts record.
- `level_o`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `ovf_cnt_o`  out  OVF_W  count of records dropped while full; saturating.
- `nop_exit_o`  out  1  sticky: `l.nop 1` retired while capturing.
- `nop_report_o`  out  1  one-cycle pulse: `l.nop 2` retired while capturing.
- `halted_o`  out  1  FSM in HALT.

## Operation
- FSM states IDLE, RUN, HALT; reset state IDLE.
  - IDLE→RUN when `enable_i`=1.
  - RUN→IDLE when `enable_i`=0.
  - RUN→HALT when an accepted retire has `wb_insn_i`=32'h1500_0001.
  - HALT is left only by `rst`.
- Capture: a retire is accepted when state=RUN and `wb_valid_i`=1 in that same cycle.
  - An accepted retire pushes {pc, insn} if FIFO not full, or if full with a pop in the same cycle.
  - Otherwise the record is dropped and `ovf_cnt_o` increments, holding at all-ones.
  - The exit `l.nop` itself follows the same push/drop rule.
- `l.nop` decode: exact-match 32'h1500_0001 (exit) and 32'h1500_0002 (report), on accepted retires only. Other `l.nop` codes (e.g. 32'h1500_0004 putc) are traced, not flagged.
- `nop_exit_o` sets on the exit retire and holds until `rst`. `nop_report_o` is high for exactly the cycle after the report retire.
- Drain: pop when `m_valid_o` & `m_ready_i`. `m_data_o` is the head entry and holds stable while `m_valid_o`=1 and not popped. Draining continues in IDLE and HALT.
- Reset values: `m_valid_o`=0, `m_data_o`=0, `level_o`=0, `ovf_cnt_o`=0, `nop_exit_o`=0, `nop_report_o`=0, `halted_o`=0. Pointers cleared; FIFO contents discarded.
- `rst` mid-transfer drops all queued records immediately (asynchronous). There is no partial-handshake recovery.

## Timing
- Push latency: retire at edge N gives `m_valid_o`=1 and `level_o` updated after edge N. No same-cycle bypass from `wb_*` to `m_data_o`.
- Empty with simultaneous push: record visible next cycle; nothing pops that cycle.
- Full with simultaneous push and pop: both occur; `level_o` stays at 2^DEPTH_LOG2; no overflow count.
- Full without pop: drop; `level_o` unchanged.
- `level_o` = previous + push − pop, every cycle.
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
- FSM transitions and flag updates take effect on the edge following the triggering input.
- `halted_o` = 1 from the cycle after the exit retire.

## Structure
- Package `or1200_trace_pkg`:
  - `NOP_EXIT`=32'h1500_0001, `NOP_REPORT`=32'h1500_0002, `NOP_PUTC`=32'h1500_0004.
  - `TRACE_W`=64.
  - FSM state encoding.
- Sub-module `or1200_trace_fifo`: synchronous FIFO, FWFT head output, parameterised by width and depth, exposing full/empty/level.
- Top level holds the FSM, nop decode, overflow counter and flags.

## Test plan
- Basic trace: enable, retire pc=0x100/insn=0xE0001000 and pc=0x104/insn=0x15000000, `m_ready_i`=1 → two records 0x00000100_E0001000 then 0x00000104_15000000 in order, each valid the cycle after retire.
- Overflow: `m_ready_i`=0, 20 back-to-back retires → `level_o`=16, `ovf_cnt_o`=4; first 16 records drain intact.
- Full with push+pop: FIFO full, `m_ready_i`=1, continuous retires → `level_o` stays 16, `ovf_cnt_o` unchanged.
- Exit: retire 0x15000001 then 3 more retires → exit record traced, `nop_exit_o`=1 and `halted_o`=1 next cycle, later retires ignored, FIFO still drains.
- Report/disable: retire 0x15000002 → `nop_report_o` single-cycle pulse. Drop `enable_i`, retire → no push, `ovf_cnt_o` unchanged.
- Async reset mid-drain with `level_o`=5 → all outputs zero immediately, FSM IDLE.
